// File: rtl/pwm_ramp_sequencer.sv
// PWM duty ramp sequencer: walks duty toward a commanded target, updating only at PWM period boundaries.
// Build option PWM_RAMP_IRQ_EN adds a sticky completion interrupt (irq_o, cleared by irq_clr_i).
module pwm_ramp_sequencer #(
    parameter int N      = 10,
    parameter int STEP_W = 4,
    parameter int DIV_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      period_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [N-2:0]      cmd_target_i,
    input  logic [STEP_W-1:0] cmd_step_i,
    input  logic [DIV_W-1:0]  cmd_div_i,
    input  logic              abort_i,
`ifdef PWM_RAMP_IRQ_EN
    input  logic              irq_clr_i,
    output logic              irq_o,
`endif
    output logic [N-2:0]      duty_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2
    } state_e;

    localparam logic [N-1:0]      CNT_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]  DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    // Widened to N bits so neither direction can wrap before clamping to the target.
    function automatic logic [N-2:0] ramp_next(
        input logic              up,
        input logic [N-2:0]      cur,
        input logic [STEP_W-1:0] stp,
        input logic [N-2:0]      tgt
    );
        logic [N-1:0] cur_w;
        logic [N-1:0] stp_w;
        logic [N-1:0] tgt_w;
        logic [N-1:0] res_w;
        cur_w = {1'b0, cur};
        stp_w = {{(N-STEP_W){1'b0}}, stp};
        tgt_w = {1'b0, tgt};
        if (up) begin
            res_w = cur_w + stp_w;
            if (res_w >= tgt_w) begin
                res_w = tgt_w;
            end else begin
                res_w = cur_w + stp_w;
            end
        end else begin
            res_w = cur_w - stp_w;
            if ((stp_w > cur_w) || (res_w <= tgt_w)) begin
                res_w = tgt_w;
            end else begin
                res_w = cur_w - stp_w;
            end
        end
        return res_w[N-2:0];
    endfunction

    state_e              state_q, state_d;
    logic [N-2:0]        duty_q, duty_d;
    logic [N-2:0]        target_q, target_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [DIV_W-1:0]    div_ld_q, div_ld_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [N-1:0]        cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                tick_s;
    logic                cmd_ready_s;
    logic [STEP_W-1:0]   step_eff_s;
    logic [DIV_W-1:0]    div_eff_s;
    logic [N-2:0]        next_duty_s;

    assign cmd_ready_s = (state_q == ST_IDLE) && !abort_i;
    assign step_eff_s  = (cmd_step_i == '0) ? STEP_ONE : cmd_step_i;
    assign div_eff_s   = (cmd_div_i == '0) ? DIV_ONE : cmd_div_i;
    assign next_duty_s = ramp_next(state_q == ST_RAMP_UP, duty_q, step_q, target_q);

    // Free-running period counter 1..period; a zero period never ticks.
    always_comb begin
        tick_s = 1'b0;
        cnt_d  = cnt_q;
        if ((period_i != '0) && (cnt_q == period_i)) begin
            tick_s = 1'b1;
            cnt_d  = CNT_ONE;
        end else begin
            cnt_d  = cnt_q + CNT_ONE;
        end
    end

    // Ramp FSM next-state, duty update and divider control.
    always_comb begin
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        div_ld_d = div_ld_q;
        div_d    = div_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_s) begin
                    target_d = cmd_target_i;
                    step_d   = step_eff_s;
                    div_ld_d = div_eff_s;
                    div_d    = div_eff_s;
                    if (cmd_target_i > duty_q) begin
                        state_d = ST_RAMP_UP;
                    end else if (cmd_target_i < duty_q) begin
                        state_d = ST_RAMP_DOWN;
                    end else begin
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RAMP_UP, ST_RAMP_DOWN: begin
                // Abort has priority over a coincident tick so duty is frozen.
                if (abort_i) begin
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (div_q == DIV_ONE) begin
                        duty_d = next_duty_s;
                        div_d  = div_ld_q;
                        if (next_duty_s == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        div_d = div_q - DIV_ONE;
                    end
                end else begin
                    div_d = div_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            duty_q   <= '0;
            target_q <= '0;
            step_q   <= '0;
            div_ld_q <= '0;
            div_q    <= '0;
            cnt_q    <= CNT_ONE;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            step_q   <= step_d;
            div_ld_q <= div_ld_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

`ifdef PWM_RAMP_IRQ_EN
    logic irq_q, irq_d;

    // Sticky completion flag; a done pulse outranks a coincident clear.
    always_comb begin
        irq_d = irq_q;
        if (done_q) begin
            irq_d = 1'b1;
        end else if (irq_clr_i) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Interrupt flag register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign irq_o = irq_q;
`endif

    assign cmd_ready_o = cmd_ready_s;
    assign duty_o      = duty_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: table of ramp commands with a duty scoreboard,
// plus directed reset-mid-ramp, abort and (with PWM_RAMP_IRQ_EN) interrupt sequences.
module tb_pwm_ramp_sequencer;

    localparam int N      = 10;
    localparam int STEP_W = 4;
    localparam int DIV_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      period;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [N-2:0]      cmd_target;
    logic [STEP_W-1:0] cmd_step;
    logic [DIV_W-1:0]  cmd_div;
    logic              abort;
    logic [N-2:0]      duty;
    logic              busy;
    logic              done;
`ifdef PWM_RAMP_IRQ_EN
    logic              irq_clr;
    logic              irq;
`endif

    pwm_ramp_sequencer #(.N(N), .STEP_W(STEP_W), .DIV_W(DIV_W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .period_i     (period),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_target_i (cmd_target),
        .cmd_step_i   (cmd_step),
        .cmd_div_i    (cmd_div),
        .abort_i      (abort),
`ifdef PWM_RAMP_IRQ_EN
        .irq_clr_i    (irq_clr),
        .irq_o        (irq),
`endif
        .duty_o       (duty),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int target;
        int step;
        int div;
        int n_upd;
        int final_duty;
    } vec_t;

    vec_t vecs[8];
    int   exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_duty = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Push the expected duty sequence, issue the command, then pop/compare on every duty change.
    task automatic run_cmd(input vec_t v);
        int d, s, dv, t, upd, last, prev, busy_gap;
        bit got_done, ramping;
        s  = (v.step == 0) ? 1 : v.step;
        dv = (v.div == 0) ? 1 : v.div;
        t  = v.target;
        d  = model_duty;
        ramping = (t != model_duty);
        exp_q.delete();
        while (d != t) begin
            if (t > d) d = (d + s >= t) ? t : d + s;
            else       d = ((s > d) || (d - s <= t)) ? t : d - s;
            exp_q.push_back(d);
        end
        @(negedge clk);
        period = v.period[N-1:0];
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_target = v.target[N-2:0];
        cmd_step   = v.step[STEP_W-1:0];
        cmd_div    = v.div[DIV_W-1:0];
        cmd_valid  = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        upd = 0; last = -1; prev = model_duty; got_done = 1'b0; busy_gap = 0;
        for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            @(negedge clk);
            if (int'(duty) != prev) begin
                upd++;
                if (exp_q.size() == 0) chk("unexpected_update", int'(duty), -1);
                else chk("duty_value", int'(duty), exp_q.pop_front());
                if (last >= 0) chk("update_spacing", cyc - last, v.period * dv);
                last = cyc;
                prev = int'(duty);
            end
            if (done) got_done = 1'b1;
            else if (ramping && (busy !== 1'b1)) busy_gap++;
        end
        if (!got_done) chk("done_timeout", 0, 1);
        chk("busy_during_ramp", busy_gap, 0);
        chk("update_count", upd, v.n_upd);
        chk("final_duty", int'(duty), v.final_duty);
        chk("busy_at_done", int'(busy), 0);
        chk("ready_at_done", int'(cmd_ready), 1);
        chk("scoreboard_empty", exp_q.size(), 0);
        @(negedge clk);
        chk("done_single_cycle", int'(done), 0);
        model_duty = v.final_duty;
    endtask

    initial begin
        int waited, done_seen;
        vecs[0] = '{period: 4, target: 10,  step: 3,  div: 1, n_upd: 4,  final_duty: 10};
        vecs[1] = '{period: 4, target: 2,   step: 4,  div: 2, n_upd: 2,  final_duty: 2};
        vecs[2] = '{period: 1, target: 500, step: 15, div: 1, n_upd: 34, final_duty: 500};
        vecs[3] = '{period: 2, target: 511, step: 15, div: 1, n_upd: 1,  final_duty: 511};
        vecs[4] = '{period: 3, target: 0,   step: 15, div: 0, n_upd: 35, final_duty: 0};
        vecs[5] = '{period: 2, target: 3,   step: 0,  div: 1, n_upd: 3,  final_duty: 3};
        vecs[6] = '{period: 2, target: 3,   step: 5,  div: 1, n_upd: 0,  final_duty: 3};
        vecs[7] = '{period: 2, target: 1,   step: 1,  div: 3, n_upd: 2,  final_duty: 1};

        rst_n = 1'b0; period = 10'd4; cmd_valid = 1'b0; cmd_target = '0;
        cmd_step = '0; cmd_div = '0; abort = 1'b0;
`ifdef PWM_RAMP_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_duty", int'(duty), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ready", int'(cmd_ready), 1);
`ifdef PWM_RAMP_IRQ_EN
        chk("reset_irq", int'(irq), 0);
`endif
        rst_n = 1'b1;
        model_duty = 0;

        for (int i = 0; i < 8; i++) run_cmd(vecs[i]);

        // Reset pulse in the middle of a ramp.
        @(negedge clk);
        period = 10'd4; cmd_target = 9'd10; cmd_step = 4'd3; cmd_div = 8'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waited = 0;
        while ((int'(duty) == model_duty) && (waited < 100)) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) chk("reset_ramp_timeout", 0, 1);
        chk("reset_ramp_busy_before", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midramp_reset_duty", int'(duty), 0);
        chk("midramp_reset_busy", int'(busy), 0);
        chk("midramp_reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_duty = 0;

        // Abort one clock before the second update of the 3,6,9,10 ramp.
        @(negedge clk);
        period = 10'd4; cmd_target = 9'd10; cmd_step = 4'd3; cmd_div = 8'd1; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        waited = 0; done_seen = 0;
        while ((duty == 9'd0) && (waited < 100)) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) chk("abort_ramp_timeout", 0, 1);
        chk("abort_first_update", int'(duty), 3);
        repeat (2) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        abort = 1'b1; cmd_valid = 1'b1;
        @(negedge clk);
        if (done) done_seen++;
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_duty_held", int'(duty), 3);
        chk("abort_blocks_ready", int'(cmd_ready), 0);
        @(negedge clk);
        if (done) done_seen++;
        chk("abort_no_accept", int'(busy), 0);
        chk("abort_tick_no_update", int'(duty), 3);
        abort = 1'b0; cmd_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("abort_duty_final", int'(duty), 3);
        chk("abort_no_done", done_seen, 0);
        model_duty = 3;

`ifdef PWM_RAMP_IRQ_EN
        // Clear the sticky flag left by earlier ramps, then exercise set and set-wins-over-clear.
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_cleared", int'(irq), 0);
        cmd_target = 9'd3; cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("equal_cmd_done", int'(done), 1);
        @(negedge clk);
        chk("irq_set_on_done", int'(irq), 1);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_clr", int'(irq), 0);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("equal_cmd_done2", int'(done), 1);
        irq_clr = 1'b1;
        @(negedge clk);
        chk("irq_set_wins", int'(irq), 1);
        @(negedge clk);
        irq_clr = 1'b0;
        chk("irq_clr_after_set", int'(irq), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
